rf_read_stage: RTL
==================

Name: rf_read_stage

Overview:
- Pipeline stage directly downstream of the 32x64 register file.
- Captures the two register-file read operands plus destination info and presents them to the execute stage through a valid/ready interface.
- Contains a 2-entry skid buffer, so `in_ready` is a registered signal.
- Operands are kept coherent with writeback by forwarding on capture and by snooping while entries are held.

Parameters:
- DATA_W, 64, operand width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  upstream has a decoded instruction.
- in_ready  out  1  stage can accept; registered.
- rs1_addr  in  ADDR_W  source 1 address (the Read1 address).
- rs2_addr  in  ADDR_W  source 2 address (the Read2 address).
- rf_data1  in  DATA_W  register-file data_out1.
- rf_data2  in  DATA_W  register-file data_out2.
- rd_addr  in  ADDR_W  destination register.
- rd_we  in  1  instruction writes rd.
- wb_we  in  1  writeback is writing this cycle.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  discard all held entries.
- out_valid  out  1  an operand bundle is available.
- out_ready  in  1  execute stage accepts.
- op_a  out  DATA_W  operand 1.
- op_b  out  DATA_W  operand 2.
- ex_rs1  out  ADDR_W  source 1 address of the head entry.
- ex_rs2  out  ADDR_W  source 2 address of the head entry.
- ex_rd  out  ADDR_W  destination register of the head entry.
- ex_we  out  1  write enable of the head entry.

Behaviour:
- Reset (rst_n=0 at the edge):
  - state EMPTY.
  - out_valid=0, in_ready=1.
  - op_a, op_b, ex_rs1, ex_rs2, ex_rd = 0; ex_we = 0.
  - Reset overrides any in-flight transfer.
- Transfers:
  - Accept occurs when in_valid & in_ready.
  - Issue occurs when out_valid & out_ready.
- Storage:
  - Two entries, HEAD (drives the outputs) and SKID.
  - Each entry holds opA, opB, rs1, rs2, rd, we.
- States and transitions:
  - EMPTY: on accept, load HEAD and go to ONE.
  - ONE:
    - accept and issue together: reload HEAD, stay in ONE.
    - accept only: load SKID, go to FULL.
    - issue only: go to EMPTY.
  - FULL:
    - in_ready=0.
    - On issue: SKID moves to HEAD, go to ONE.
- Output decodes:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered from the next-state value.
- Capture forwarding:
  - When an entry is captured, opA = (wb_we & wb_addr==rs1_addr) ? wb_data : rf_data1.
  - opB is formed the same way from rs2_addr and rf_data2.
  - The register file updates at the same edge, so rf_data still holds the old value; forwarding is required.
- Snoop:
  - Every cycle, each held entry whose rs1 (rs2) equals wb_addr while wb_we=1 replaces opA (opB) with wb_data.
  - Applies to the SKID entry moving to HEAD as well.
  - An issuing HEAD needs no update.
- Simultaneous writeback to both sources (rs1==rs2==wb_addr): both operands are updated.
- Flush:
  - Next state EMPTY, out_valid=0, in_ready=1.
  - An accept in the same cycle is dropped.
  - Flush is ignored during reset.
- Latency:
  - 1 cycle from accept to out_valid.
  - Throughput is 1 per cycle when out_ready is held high.
- Ordering is strict FIFO; no entry is ever lost or duplicated.

Optional Feature:
- Macro REG0_ZERO_EN.
- Defined:
  - A source address of 0 yields an operand of 0, regardless of rf_data.
  - wb_addr==0 never forwards or snoops.
  - ex_we is forced to 0 when rd_addr==0.
- Undefined: register 0 is an ordinary register and is forwarded like any other.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W constants.
  - State encoding: EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
  - Entry bundle typedef (opA, opB, rs1, rs2, rd, we).
- One sub-module, operand_fwd: the combinational address-compare/mux for one operand.
  - Instantiated for capture of each operand.
  - Instantiated for snoop of each stored operand.

Test Plan:
- Reset then single accept (rs1=3, rf_data1=0x11, out_ready=1) -> out_valid=1 next cycle, op_a=0x11, then EMPTY.
- Capture forwarding: accept rs2=7 with wb_we=1, wb_addr=7, wb_data=0xDEAD -> op_b=0xDEAD, not rf_data2.
- Backpressure: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 after second; release out_ready -> bundles issued in order 1,2, then third accepted.
- Snoop while held: FULL with SKID rs1=5; wb writes 5<=0x42 -> after SKID reaches HEAD, op_a=0x42.
- Flush in FULL with concurrent in_valid -> out_valid=0 next cycle, in_ready=1, nothing issued.
- REG0_ZERO_EN: rs1=0, rf_data1=0xFF, wb_addr=0, wb_data=0x9 -> op_a=0; without the macro -> op_a=0x9.

Source files
------------

// File: rtl/rf_read_stage_pkg.sv
// Shared constants, state encoding and entry bundle for the register-file read stage.
package rf_read_stage_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } entry_t;

endpackage

// File: rtl/rf_read_stage_operand_fwd.sv
// Writeback compare/mux for one operand; used at capture and for snooping held entries.
// REG0_ZERO_EN makes register 0 read as zero and never forward.
module operand_fwd #(
    parameter int unsigned DATA_W = rf_read_stage_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_read_stage_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [DATA_W-1:0] i_cur_data,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit;

`ifdef REG0_ZERO_EN
    assign w_hit  = i_wb_we && (i_wb_addr == i_src_addr) && (i_wb_addr != '0);
    assign o_data = (i_src_addr == '0) ? '0 : (w_hit ? i_wb_data : i_cur_data);
`else
    assign w_hit  = i_wb_we && (i_wb_addr == i_src_addr);
    assign o_data = w_hit ? i_wb_data : i_cur_data;
`endif

endmodule

// File: rtl/rf_read_stage.sv
// Register-file read stage: 2-entry skid buffer with capture forwarding and writeback snooping.
// Optional macro REG0_ZERO_EN hard-wires register 0 to zero.
module rf_read_stage #(
    parameter int unsigned DATA_W = rf_read_stage_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_read_stage_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_we,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] ex_rs2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_we
);

    import rf_read_stage_pkg::*;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_in_ready;
    entry_t            r_head;
    entry_t            r_skid;
    entry_t            w_cap;
    entry_t            w_head_snp;
    entry_t            w_skid_snp;
    logic [DATA_W-1:0] w_cap_a, w_cap_b;
    logic [DATA_W-1:0] w_head_a, w_head_b;
    logic [DATA_W-1:0] w_skid_a, w_skid_b;
    logic              w_accept, w_issue, w_cap_we;
    logic              w_load_head, w_load_skid, w_promote;

    assign w_accept = in_valid && r_in_ready;
    assign w_issue  = out_valid && out_ready;

    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_a (
        .i_src_addr(rs1_addr), .i_cur_data(rf_data1), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_cap_a));
    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_b (
        .i_src_addr(rs2_addr), .i_cur_data(rf_data2), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_cap_b));
    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head_a (
        .i_src_addr(r_head.rs1), .i_cur_data(r_head.opa), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_head_a));
    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head_b (
        .i_src_addr(r_head.rs2), .i_cur_data(r_head.opb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_head_b));
    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid_a (
        .i_src_addr(r_skid.rs1), .i_cur_data(r_skid.opa), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_skid_a));
    operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid_b (
        .i_src_addr(r_skid.rs2), .i_cur_data(r_skid.opb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_skid_b));

`ifdef REG0_ZERO_EN
    assign w_cap_we = rd_we && (rd_addr != '0);
`else
    assign w_cap_we = rd_we;
`endif

    always_comb begin
        w_cap.opa      = w_cap_a;
        w_cap.opb      = w_cap_b;
        w_cap.rs1      = rs1_addr;
        w_cap.rs2      = rs2_addr;
        w_cap.rd       = rd_addr;
        w_cap.we       = w_cap_we;
        w_head_snp     = r_head;
        w_head_snp.opa = w_head_a;
        w_head_snp.opb = w_head_b;
        w_skid_snp     = r_skid;
        w_skid_snp.opa = w_skid_a;
        w_skid_snp.opb = w_skid_b;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_load_skid  = 1'b0;
        w_promote    = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_accept) begin
                w_state_next = ST_ONE;
                w_load_head  = 1'b1;
            end
            ST_ONE: begin
                if (w_accept && w_issue) begin
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_issue) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: if (w_issue) begin
                w_promote    = 1'b1;
                w_state_next = ST_ONE;
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // Flush drops any same-cycle accept along with the held entries.
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_load_head  = 1'b0;
            w_load_skid  = 1'b0;
            w_promote    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
            if (w_load_head)    r_head <= w_cap;
            else if (w_promote) r_head <= w_skid_snp;
            else                r_head <= w_head_snp;
            if (w_load_skid) r_skid <= w_cap;
            else             r_skid <= w_skid_snp;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign op_a      = r_head.opa;
    assign op_b      = r_head.opb;
    assign ex_rs1    = r_head.rs1;
    assign ex_rs2    = r_head.rs2;
    assign ex_rd     = r_head.rd;
    assign ex_we     = r_head.we;

endmodule
